// File: rtl/spi_master_param.sv
// Parametrised SPI master: valid/ready word in, one full-duplex frame in any
// SPI mode on a selectable chip select, received word returned with a strobe.
module spi_master_param #(
  parameter int DATA_W    = 8,
  parameter int HALF_DIV  = 4,
  parameter int NUM_CS    = 2,
  parameter int MSB_FIRST = 1,
  localparam int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int CNT_W  = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [EDGE_W-1:0]   r_edge;
  logic [DATA_W-1:0]   r_tx;
  logic [DATA_W-1:0]   r_rx;
  logic [DATA_W-1:0]   r_rx_data;
  logic                r_cpol;
  logic                r_cpha;
  logic                r_sclk;
  logic                r_mosi;
  logic                r_rx_valid;
  logic [NUM_CS-1:0]   r_cs_n;

  logic                w_half_end;
  logic                w_last_edge;
  logic                w_leading;
  logic                w_sample;
  logic                w_advance;
  logic                w_first_bit;
  logic                w_next_bit;
  logic [DATA_W-1:0]   w_tx_next;
  logic [DATA_W-1:0]   w_rx_shift;
  logic [NUM_CS-1:0]   w_cs_dec;

  always_comb begin
    w_half_end  = (r_cnt == CNT_W'(HALF_DIV - 1));
    w_last_edge = (r_edge == EDGE_W'(2 * DATA_W - 1));
    w_leading   = ~r_edge[0];
    w_sample    = w_leading ^ r_cpha;
    // cpha=1 presents the first bit before the first leading edge, so that edge only re-presents it
    w_advance   = r_cpha ? (w_leading && (r_edge != '0)) : (~w_leading && ~w_last_edge);
    if (MSB_FIRST != 0) begin
      w_first_bit = tx_data[DATA_W-1];
      w_tx_next   = r_tx << 1;
      w_next_bit  = w_tx_next[DATA_W-1];
      w_rx_shift  = {r_rx[DATA_W-2:0], miso};
    end else begin
      w_first_bit = tx_data[0];
      w_tx_next   = r_tx >> 1;
      w_next_bit  = w_tx_next[0];
      w_rx_shift  = {miso, r_rx[DATA_W-1:1]};
    end
  end

  // Out-of-range selects leave every line deasserted
  always_comb begin
    w_cs_dec = '1;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (32'(cs_sel) == i) w_cs_dec[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_edge     <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_cs_n     <= '1;
    end else begin
      r_rx_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (tx_valid) begin
            r_tx    <= tx_data;
            r_cpol  <= cpol;
            r_cpha  <= cpha;
            r_sclk  <= cpol;
            r_cs_n  <= w_cs_dec;
            r_mosi  <= w_first_bit;
            r_cnt   <= '0;
            r_edge  <= '0;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_half_end) begin
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (w_half_end) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
            r_edge <= r_edge + 1'b1;
            if (w_sample) r_rx <= w_rx_shift;
            if (w_advance) begin
              r_tx   <= w_tx_next;
              r_mosi <= w_next_bit;
            end
            if (w_last_edge) begin
              // with cpha=1 the final sample lands on this same edge
              r_rx_data  <= w_sample ? w_rx_shift : r_rx;
              r_rx_valid <= 1'b1;
              r_state    <= S_HOLD;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (w_half_end) begin
            r_cnt   <= '0;
            r_cs_n  <= '1;
            r_mosi  <= 1'b0;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (w_half_end) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_ready = (r_state == S_IDLE) && !rst;
  assign busy     = (r_state != S_IDLE);
  assign sclk     = r_sclk;
  assign mosi     = r_mosi;
  assign cs_n     = r_cs_n;
  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: an MSB-first 2-CS instance and an LSB-first 3-CS
// instance driven side by side and checked cycle by cycle against a timing model.
module tb_spi_master_param;

  localparam int W    = 8;
  localparam int H    = 2;
  localparam int P    = H * (2 * W + 3);  // transfer edge to tx_ready re-high
  localparam int RXC  = H * (2 * W + 1);  // rx_valid cycle
  localparam int CSE  = H * (2 * W + 2);  // first cycle with cs_n released

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic [1:0] cs_sel;
  logic       cpol, cpha;
  logic [1:0] miso_mode;  // 0 loopback, 1 tied 0, 2 tied 1, 3 inverted loopback

  logic       tx_ready_a, rx_valid_a, busy_a, sclk_a, mosi_a, miso_a;
  logic [7:0] rx_data_a;
  logic [1:0] cs_n_a;
  logic       tx_ready_b, rx_valid_b, busy_b, sclk_b, mosi_b, miso_b;
  logic [7:0] rx_data_b;
  logic [2:0] cs_n_b;

  int total = 0;
  int bad   = 0;
  logic [7:0] prev_a = 8'h00;
  logic [7:0] prev_b = 8'h00;

  always #5 clk = ~clk;

  assign miso_a = (miso_mode == 2'd0) ? mosi_a : (miso_mode == 2'd1) ? 1'b0 :
                  (miso_mode == 2'd2) ? 1'b1 : ~mosi_a;
  assign miso_b = (miso_mode == 2'd0) ? mosi_b : (miso_mode == 2'd1) ? 1'b0 :
                  (miso_mode == 2'd2) ? 1'b1 : ~mosi_b;

  spi_master_param #(.DATA_W(W), .HALF_DIV(H), .NUM_CS(2), .MSB_FIRST(1)) u_dut_a (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready_a),
    .tx_data(tx_data), .cs_sel(cs_sel[0]), .cpol(cpol), .cpha(cpha),
    .rx_valid(rx_valid_a), .rx_data(rx_data_a), .busy(busy_a), .sclk(sclk_a),
    .mosi(mosi_a), .miso(miso_a), .cs_n(cs_n_a)
  );

  spi_master_param #(.DATA_W(W), .HALF_DIV(H), .NUM_CS(3), .MSB_FIRST(0)) u_dut_b (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready_b),
    .tx_data(tx_data), .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha),
    .rx_valid(rx_valid_b), .rx_data(rx_data_b), .busy(busy_b), .sclk(sclk_b),
    .mosi(mosi_b), .miso(miso_b), .cs_n(cs_n_b)
  );

  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; cs_sel = 2'd0;
    cpol = 1'b0; cpha = 1'b0; miso_mode = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({tx_ready_a, tx_ready_b} !== 2'b00) begin
      bad++; $display("FAIL reset_ready_low got=%b want=00", {tx_ready_a, tx_ready_b});
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({tx_ready_a, tx_ready_b} !== 2'b11) begin
      bad++; $display("FAIL reset_ready_high got=%b want=11", {tx_ready_a, tx_ready_b});
    end
    total++;
    if ({sclk_a, mosi_a, busy_a, rx_valid_a, cs_n_a, rx_data_a} !== {4'b0000, 2'b11, 8'h00}) begin
      bad++; $display("FAIL reset_state_a got=%b want=%b",
                      {sclk_a, mosi_a, busy_a, rx_valid_a, cs_n_a, rx_data_a}, {4'b0000, 2'b11, 8'h00});
    end
    total++;
    if ({sclk_b, mosi_b, busy_b, rx_valid_b, cs_n_b, rx_data_b} !== {4'b0000, 3'b111, 8'h00}) begin
      bad++; $display("FAIL reset_state_b got=%b want=%b",
                      {sclk_b, mosi_b, busy_b, rx_valid_b, cs_n_b, rx_data_b}, {4'b0000, 3'b111, 8'h00});
    end
  endtask

  // Directed table entries [first..last], then nrand random frames with mid-frame input noise.
  task automatic test_frames(input int first, input int last, input int nrand);
    logic [7:0] td[5] = '{8'h5A, 8'hA5, 8'h3C, 8'h01, 8'h96};
    logic [1:0] tmode[5] = '{2'b00, 2'b00, 2'b11, 2'b01, 2'b10};  // {cpol,cpha}
    logic [1:0] tcs[5] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd3};
    logic [1:0] tmiso[5] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd3};
    logic [7:0] d, rxe;
    logic [1:0] cs, mm;
    logic       pl, ph, noise, e_sclk, e_mosi_a, e_mosi_b, e_busy, e_rdy, e_rxv;
    logic [1:0] e_cs_a;
    logic [2:0] e_cs_b;
    int t, idx;
    for (int n = first; n <= last + nrand; n++) begin
      if (n <= last) begin
        d = td[n]; {pl, ph} = tmode[n]; cs = tcs[n]; mm = tmiso[n]; noise = 1'b0;
      end else begin
        d = 8'($urandom); pl = 1'($urandom); ph = 1'($urandom);
        cs = 2'($urandom_range(0, 3)); mm = 2'($urandom_range(0, 3)); noise = 1'b1;
      end
      case (mm)
        2'd0: rxe = d;
        2'd1: rxe = 8'h00;
        2'd2: rxe = 8'hFF;
        default: rxe = ~d;
      endcase
      @(negedge clk);
      total++;
      if ({tx_ready_a, tx_ready_b} !== 2'b11) begin
        bad++; $display("FAIL frame%0d idle_ready got=%b want=11", n, {tx_ready_a, tx_ready_b});
      end
      tx_valid = 1'b1; tx_data = d; cs_sel = cs; cpol = pl; cpha = ph; miso_mode = mm;
      @(posedge clk);
      #1 tx_valid = 1'b0;
      for (int c = 0; c <= P; c++) begin
        @(negedge clk);
        t = (c < H) ? 0 : (((c - H) / H > 2 * W) ? 2 * W : (c - H) / H);
        idx = ph ? ((t == 0) ? 0 : (t - 1) / 2) : ((t / 2 > W - 1) ? W - 1 : t / 2);
        e_sclk   = pl ^ ((t % 2) != 0);
        e_mosi_a = (c < CSE) ? d[W-1-idx] : 1'b0;
        e_mosi_b = (c < CSE) ? d[idx] : 1'b0;
        e_busy   = (c < P);
        e_rdy    = (c == P);
        e_rxv    = (c == RXC);
        e_cs_a   = (c < CSE) ? ~(2'b01 << cs[0]) : 2'b11;
        e_cs_b   = (c < CSE && cs != 2'd3) ? ~(3'b001 << cs) : 3'b111;
        total++;
        if ({sclk_a, mosi_a, busy_a, tx_ready_a, rx_valid_a} !== {e_sclk, e_mosi_a, e_busy, e_rdy, e_rxv}) begin
          bad++; $display("FAIL frame%0d c=%0d ctrl_a(sclk,mosi,busy,rdy,rxv) got=%b want=%b", n, c,
                          {sclk_a, mosi_a, busy_a, tx_ready_a, rx_valid_a}, {e_sclk, e_mosi_a, e_busy, e_rdy, e_rxv});
        end
        total++;
        if ({sclk_b, mosi_b, busy_b, tx_ready_b, rx_valid_b} !== {e_sclk, e_mosi_b, e_busy, e_rdy, e_rxv}) begin
          bad++; $display("FAIL frame%0d c=%0d ctrl_b(sclk,mosi,busy,rdy,rxv) got=%b want=%b", n, c,
                          {sclk_b, mosi_b, busy_b, tx_ready_b, rx_valid_b}, {e_sclk, e_mosi_b, e_busy, e_rdy, e_rxv});
        end
        total++;
        if ({cs_n_a, cs_n_b} !== {e_cs_a, e_cs_b}) begin
          bad++; $display("FAIL frame%0d c=%0d cs_n got=%b/%b want=%b/%b", n, c, cs_n_a, cs_n_b, e_cs_a, e_cs_b);
        end
        total++;
        if (rx_data_a !== ((c >= RXC) ? rxe : prev_a)) begin
          bad++; $display("FAIL frame%0d c=%0d rx_data_a got=%h want=%h", n, c, rx_data_a, (c >= RXC) ? rxe : prev_a);
        end
        total++;
        if (rx_data_b !== ((c >= RXC) ? rxe : prev_b)) begin
          bad++; $display("FAIL frame%0d c=%0d rx_data_b got=%h want=%h", n, c, rx_data_b, (c >= RXC) ? rxe : prev_b);
        end
        if (noise && c < P - 1) begin
          tx_valid = 1'($urandom); tx_data = 8'($urandom); cs_sel = 2'($urandom);
          cpol = 1'($urandom); cpha = 1'($urandom);
        end else begin
          tx_valid = 1'b0;
        end
      end
      prev_a = rxe;
      prev_b = rxe;
    end
  endtask

  task automatic test_back_to_back();
    int hs = -1;
    int gap_hi = 0;
    int bad_cs = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'h3C; cs_sel = 2'd1; cpol = 1'b0; cpha = 1'b0; miso_mode = 2'd0;
    @(posedge clk);
    #1 tx_data = 8'hC3;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (hs >= 0 && c == hs + 1) tx_valid = 1'b0;
      if (hs < 0 && cs_n_a === 2'b11) gap_hi++;
      if (hs < 0 && tx_ready_a === 1'b1) hs = c;
      if (cs_n_a !== 2'b01 && cs_n_a !== 2'b11) bad_cs++;
      if (rx_valid_a === 1'b1) qa.push_back(rx_data_a);
      if (rx_valid_b === 1'b1) qb.push_back(rx_data_b);
    end
    tx_valid = 1'b0;
    total++;
    if (hs != P) begin
      bad++; $display("FAIL b2b_second_handshake_cycle got=%0d want=%0d", hs, P);
    end
    total++;
    if (gap_hi < H + 1) begin
      bad++; $display("FAIL b2b_cs_gap got=%0d want>=%0d", gap_hi, H + 1);
    end
    total++;
    if (bad_cs != 0) begin
      bad++; $display("FAIL b2b_cs_pattern got=%0d_bad_cycles want=0", bad_cs);
    end
    total++;
    if (qa.size() != 2 || qa[0] !== 8'h3C || qa[1] !== 8'hC3) begin
      bad++; $display("FAIL b2b_rx_a got=%0d_words,%h,%h want=2_words,3c,c3", qa.size(),
                      (qa.size() > 0) ? qa[0] : 8'hxx, (qa.size() > 1) ? qa[1] : 8'hxx);
    end
    total++;
    if (qb.size() != 2 || qb[0] !== 8'h3C || qb[1] !== 8'hC3) begin
      bad++; $display("FAIL b2b_rx_b got=%0d_words,%h,%h want=2_words,3c,c3", qb.size(),
                      (qb.size() > 0) ? qb[0] : 8'hxx, (qb.size() > 1) ? qb[1] : 8'hxx);
    end
    prev_a = 8'hC3;
    prev_b = 8'hC3;
  endtask

  task automatic test_reset_abort();
    int edges = 0;
    int rxv_seen = 0;
    int busy_seen = 0;
    logic last;
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'($urandom); cs_sel = 2'd0; cpol = 1'b1; cpha = 1'b1; miso_mode = 2'd0;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    last = sclk_a;
    for (int c = 0; c < 100 && edges < 5; c++) begin
      @(negedge clk);
      if (sclk_a !== last) edges++;
      last = sclk_a;
    end
    total++;
    if (edges != 5) begin
      bad++; $display("FAIL abort_sclk_edges got=%0d want=5", edges);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({sclk_a, mosi_a, busy_a, rx_valid_a, tx_ready_a, cs_n_a, rx_data_a} !== {5'b00000, 2'b11, 8'h00}) begin
      bad++; $display("FAIL abort_state_a got=%b want=%b",
                      {sclk_a, mosi_a, busy_a, rx_valid_a, tx_ready_a, cs_n_a, rx_data_a}, {5'b00000, 2'b11, 8'h00});
    end
    total++;
    if ({sclk_b, mosi_b, busy_b, rx_valid_b, tx_ready_b, cs_n_b, rx_data_b} !== {5'b00000, 3'b111, 8'h00}) begin
      bad++; $display("FAIL abort_state_b got=%b want=%b",
                      {sclk_b, mosi_b, busy_b, rx_valid_b, tx_ready_b, cs_n_b, rx_data_b}, {5'b00000, 3'b111, 8'h00});
    end
    rst = 1'b0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (rx_valid_a !== 1'b0 || rx_valid_b !== 1'b0) rxv_seen++;
      if (busy_a !== 1'b0 || busy_b !== 1'b0) busy_seen++;
    end
    total++;
    if (rxv_seen != 0) begin
      bad++; $display("FAIL abort_no_rx_valid got=%0d_pulses want=0", rxv_seen);
    end
    total++;
    if (busy_seen != 0) begin
      bad++; $display("FAIL abort_stays_idle got=%0d_busy_cycles want=0", busy_seen);
    end
    prev_a = 8'h00;
    prev_b = 8'h00;
  endtask

  initial begin
    test_reset();
    test_frames(1, 4, 12);
    test_back_to_back();
    test_reset_abort();
    test_frames(0, 0, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
